vga_fb_scheduler: RTL and testbench

Frame-buffer access scheduler for the 640x480 VGA display path. It shares one single-port, 32-bit-wide frame memory (4 x 8-bit pixels per word) between three users: display fetch, a host pixel writer, and a built-in frame-clear engine. Display fetch is never stalled. The block turns the VGA timing generator's visible-pixel coordinates into an 8-bit pixel stream for the DAC/colour LUT.

---
 rtl/vga_fb_pkg.sv | 14 +
 rtl/vga_fb_unpack.sv | 38 +++
 rtl/vga_fb_scheduler.sv | 125 ++++++++++++
 tb/tb_vga_fb_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA frame-buffer scheduler.
// The frame memory holds 640x480 8-bit pixels packed four per 32-bit word.
package vga_fb_pkg;

  localparam int unsigned          ADDR_W         = 17;
  localparam logic [ADDR_W-1:0]    FB_WORDS       = 17'd76800;
  localparam int unsigned          WORDS_PER_LINE = 160;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/vga_fb_unpack.sv
// Captures one 4-pixel memory word after each display fetch and emits its
// pixels in order, blanking the output for non-visible coordinates.
module vga_fb_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_disp_slot,
  input  logic        i_visible,
  input  logic [31:0] i_rdata,
  output logic [7:0]  o_pix
);

  logic        r_load;
  logic        r_vis;
  logic [23:0] r_shift;

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would let r_shift see the new r_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load  <= 1'b0;
      r_vis   <= 1'b0;
      r_shift <= '0;
    end else begin
      r_load <= i_disp_slot;
      r_vis  <= i_visible;
      if (r_load) begin
        r_shift <= i_rdata[31:8];
      end else begin
        r_shift <= {8'h00, r_shift[23:8]};
      end
    end
  end

  // Pixel 0 comes straight from the memory's output register so that it
  // lands one cycle after its coordinate; pixels 1..3 come from r_shift.
  assign o_pix = !r_vis ? 8'h00 : (r_load ? i_rdata[7:0] : r_shift[7:0]);

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single-port frame memory between display fetch (never
// stalled), the frame-clear engine and the host pixel writer.
module vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [10:0]       coor_x,
  input  logic [9:0]        coor_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        pix_data
);

  localparam logic [10:0]       LP_H_ACT  = 11'(H_ACTIVE);
  localparam logic [9:0]        LP_V_ACT  = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LP_WPL    = ADDR_W'(H_ACTIVE / 4);
  localparam logic [ADDR_W-1:0] LP_FB_LAST = FB_WORDS - 17'd1;

  logic              w_visible;
  logic              w_disp_slot;
  logic              w_clr_wr;
  logic [ADDR_W-1:0] w_disp_addr;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [7:0]        r_color;
  logic              r_clr_done;

  assign w_visible   = (coor_x < LP_H_ACT) && (coor_y < LP_V_ACT);
  assign w_disp_slot = w_visible && (coor_x[1:0] == 2'b00);
  assign w_disp_addr = ADDR_W'(coor_y) * LP_WPL + ADDR_W'(coor_x[10:2]);
  assign w_clr_wr    = !w_disp_slot && (r_state == ST_CLEAR);

  // Bus is gated by reset_n directly so every strobe drops the moment reset
  // is asserted, not at the next edge.
  // NOTE: each output gets a default first so no path through this block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    wr_ack    = 1'b0;
    if (reset_n) begin
      if (w_disp_slot) begin
        mem_addr = w_disp_addr;
      end else if (r_state == ST_CLEAR) begin
        mem_addr  = r_clr_cnt;
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_wdata = {4{r_color}};
      end else if (wr_req) begin
        wr_ack   = 1'b1;
        mem_addr = wr_addr;
        // Out-of-range writes are acknowledged but never reach memory.
        if (wr_addr < FB_WORDS) begin
          mem_we    = 1'b1;
          mem_be    = wr_be;
          mem_wdata = wr_data;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_color    <= 8'h00;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_color   <= clr_color;
          end
        end
        ST_CLEAR: begin
          if (w_clr_wr) begin
            if (r_clr_cnt == LP_FB_LAST) begin
              r_state    <= ST_IDLE;
              r_clr_cnt  <= '0;
              r_clr_done <= 1'b1;
            end else begin
              r_clr_cnt <= r_clr_cnt + 17'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign clr_busy = (r_state == ST_CLEAR);
  assign clr_done = r_clr_done;

  vga_fb_unpack u_unpack (
    .clk         (vga_clk),
    .rst_n       (reset_n),
    .i_disp_slot (w_disp_slot),
    .i_visible   (w_visible),
    .i_rdata     (mem_rdata),
    .o_pix       (pix_data)
  );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench: a pixel-image reference model predicts the video
// stream; a behavioural memory and monitor track what the scheduler writes.
module tb_vga_fb_scheduler;

  localparam int H = 640;
  localparam int V = 480;
  localparam int WORDS = 76800;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] coor_x = 11'd640;
  logic [9:0]  coor_y = 10'd480;
  logic        wr_req = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        wr_ack;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_color = '0;
  logic        clr_busy;
  logic        clr_done;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  pix_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference image: one byte per visible pixel, row-major.
  logic [7:0] ref_pix [0:H*V-1];

  // Environment: memory contents and clear-monitor counters.
  logic [31:0] mem [0:WORDS-1];
  bit          seen [0:WORDS-1];
  logic        mon_clr = 1'b0;
  logic [7:0]  exp_color = 8'h00;
  int clr_writes = 0, clr_distinct = 0, clr_bad = 0, ack_in_clr = 0, done_cnt = 0;

  logic hold_wr = 1'b0;

  always #5 vga_clk = ~vga_clk;

  vga_fb_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .coor_x    (coor_x),
    .coor_y    (coor_y),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .wr_ack    (wr_ack),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data)
  );

  always @(posedge vga_clk) begin
    if (mem_addr < 17'd76800) begin
      if (mem_we) begin
        for (int p = 0; p < 4; p++) begin
          if (mem_be[p]) mem[mem_addr][8*p +: 8] <= mem_wdata[8*p +: 8];
        end
      end
      mem_rdata <= mem[mem_addr];
    end else begin
      mem_rdata <= 32'hDEAD_BEEF;
    end
    if (mon_clr) begin
      clr_writes   <= 0;
      clr_distinct <= 0;
      clr_bad      <= 0;
      ack_in_clr   <= 0;
      done_cnt     <= 0;
    end else begin
      if (clr_done) done_cnt <= done_cnt + 1;
      if (wr_ack && clr_busy) ack_in_clr <= ack_in_clr + 1;
      if (mem_we && clr_busy) begin
        clr_writes <= clr_writes + 1;
        if (mem_wdata !== {4{exp_color}} || mem_be !== 4'hF) clr_bad <= clr_bad + 1;
        if (mem_addr < 17'd76800 && !seen[mem_addr]) begin
          seen[mem_addr] <= 1'b1;
          clr_distinct   <= clr_distinct + 1;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge vga_clk);
    #1;
    wr_req    = hold_wr;
    clr_start = 1'b0;
  endtask

  task automatic settle();
    @(negedge vga_clk);
  endtask

  task automatic step(input int x, input int y);
    adv();
    coor_x = 11'(x);
    coor_y = 10'(y);
    settle();
  endtask

  function automatic bit is_free(input int x, input int y);
    return !(x < H && y < V && (x % 4) == 0);
  endfunction

  // Presents one writer request starting at (x,y) and checks its grant.
  task automatic wr(input int x, input int y, input logic [16:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    int cx;
    cx = x;
    adv();
    coor_x = 11'(cx); coor_y = 10'(y);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    settle();
    if (!is_free(cx, y)) begin
      check("wr_wait_ack", wr_ack, 0);
      cx++;
      adv();
      coor_x = 11'(cx);
      wr_req = 1'b1;
      settle();
    end
    check("wr_ack", wr_ack, 1);
    check("wr_we", mem_we, 32'(a < 17'd76800));
    if (a < 17'd76800) begin
      check("wr_addr", mem_addr, a);
      check("wr_be", mem_be, be);
      check("wr_data", mem_wdata, d);
      for (int p = 0; p < 4; p++) begin
        if (be[p]) ref_pix[int'(a) * 4 + p] = d[8*p +: 8];
      end
    end
  endtask

  task automatic load_line(input int y);
    for (int k = 0; k < H / 4; k++) begin
      wr(H, y, 17'(y * (H / 4) + k), (y == 0 && k == 0) ? 32'h44332211 : $urandom, 4'hF);
    end
  endtask

  task automatic sweep(input int y);
    for (int x = 0; x <= H + 1; x++) begin
      step(x, y);
      if (x < H && (x % 4) == 0) begin
        check("disp_addr", mem_addr, 32'(y * (H / 4) + x / 4));
        check("disp_we", mem_we, 0);
      end
      if (x == 0 || x == H + 1) check("pix_blank", pix_data, 0);
      else check("pix", pix_data, ref_pix[y * H + x - 1]);
    end
    step(H, V);
  endtask

  initial begin
    int x, y, cx, cy;
    logic [16:0] a;
    bit got_done;

    // Power-on reset, then a reset asserted mid-line in a display slot.
    repeat (3) step(H, V);
    adv(); reset_n = 1'b1;
    step(99, 5);
    step(100, 5);
    wr_req = 1'b1; wr_addr = 17'h00055; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    #1 reset_n = 1'b0;
    #1;
    check("rst_pix", pix_data, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    step(H, V);
    step(H, V);
    adv(); reset_n = 1'b1;
    step(H, V);
    check("idle_busy", clr_busy, 0);
    wr(H, 10, 17'd76800, 32'h1234_5678, 4'hF);
    wr(H + 5, 3, 17'h1FFFF, 32'h8765_4321, 4'h3);

    // Load lines 0, 1 and the last line through the writer in blanking.
    load_line(0);
    load_line(1);
    load_line(V - 1);

    // Writer during active video: request in a display slot waits one cycle.
    wr(8, 3, 17'h00123, $urandom, 4'(($urandom % 15) + 1));
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, H - 1);
      y = $urandom_range(0, V - 1);
      a = ($urandom % 2) ? 17'(160 + $urandom % 160) : 17'(76640 + $urandom % 160);
      wr(x, y, a, $urandom, 4'($urandom));
    end
    step(H, V);

    sweep(0);
    sweep(1);
    sweep(V - 1);

    // Full clear: start coincides with a writer request in a free slot.
    adv();
    coor_x = 11'(H); coor_y = 10'd0;
    wr_req = 1'b1; wr_addr = 17'h00010; wr_data = 32'h0BAD_F00D; wr_be = 4'hF;
    clr_start = 1'b1; clr_color = 8'h5A; exp_color = 8'h5A; mon_clr = 1'b1;
    settle();
    check("sim_ack", wr_ack, 1);
    check("sim_addr", mem_addr, 17'h00010);
    check("sim_busy", clr_busy, 0);
    hold_wr = 1'b1;
    adv();
    mon_clr = 1'b0;
    wr_addr = 17'h00020; wr_data = 32'hCAFE_BABE; wr_be = 4'hF;
    coor_x = 11'(H + 1);
    settle();
    check("clr_busy_1", clr_busy, 1);
    check("clr_first_ack", wr_ack, 0);
    check("clr_first_we", mem_we, 1);
    check("clr_first_addr", mem_addr, 0);
    check("clr_first_data", mem_wdata, 32'h5A5A5A5A);
    check("clr_first_be", mem_be, 4'hF);

    got_done = 1'b0;
    cx = H + 1; cy = 0;
    for (int i = 0; i < 90000; i++) begin
      if (cy < 3) begin
        cx++;
        if (cx == 800) begin cx = 0; cy++; end
      end
      if (cy < 3) step(cx, cy);
      else step(H, V);
      if (i == 5000) begin
        // A second start during CLEAR must be ignored; applied next cycle.
        adv();
        clr_start = 1'b1; clr_color = 8'h00;
        settle();
      end
      if (clr_done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("clr_done_seen", 32'(got_done), 1);
    check("done_busy", clr_busy, 0);
    check("done_ack", wr_ack, 1);
    check("done_wr_addr", mem_addr, 17'h00020);
    check("done_wr_we", mem_we, 1);
    hold_wr = 1'b0;
    step(H, V);
    check("done_pulse", clr_done, 0);
    step(H, V);
    check("clr_writes", clr_writes, WORDS);
    check("clr_distinct", clr_distinct, WORDS);
    check("clr_bad", clr_bad, 0);
    check("clr_ack_stall", ack_in_clr, 0);
    check("clr_done_cnt", done_cnt, 1);

    // Abort a clear with reset after about 1000 writes, then restart.
    adv();
    clr_start = 1'b1; clr_color = 8'h3C; exp_color = 8'h3C; mon_clr = 1'b1;
    settle();
    adv(); mon_clr = 1'b0; settle();
    for (int i = 0; i < 5000; i++) begin
      if (clr_writes >= 1000) break;
      step(H, V);
    end
    check("abort_reached", 32'(clr_writes >= 1000), 1);
    adv();
    reset_n = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_we", mem_we, 0);
    step(H, V);
    adv(); reset_n = 1'b1;
    repeat (4) step(H, V);
    check("abort_busy_after", clr_busy, 0);
    check("abort_no_done", done_cnt, 0);

    adv();
    clr_start = 1'b1; clr_color = 8'hC3; exp_color = 8'hC3;
    settle();
    check("restart_busy0", clr_busy, 0);
    step(H, V);
    check("restart_busy", clr_busy, 1);
    check("restart_addr0", mem_addr, 0);
    check("restart_we", mem_we, 1);
    check("restart_data", mem_wdata, 32'hC3C3C3C3);
    step(H, V);
    check("restart_addr1", mem_addr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
